// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with prescaler, pause, abort and
// optional auto-reload; emits a one-cycle done pulse after the count reaches zero.
`default_nettype none

module down_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             reload_en,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  if (WIDTH < 1 || PRESCALE < 1) begin : g_bad_params
    $error("down_timer: WIDTH and PRESCALE must both be >= 1");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] reload_reg;
  logic             tick;
  logic             accept;

  assign load_ready = (state == IDLE) && !abort;
  assign accept     = load_valid && load_ready;
  assign tick       = (state == RUN) && en && !abort && (presc == PRESC_LAST);
  assign busy       = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      done       <= 1'b0;
      presc      <= '0;
      reload_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RUN;
            count      <= load_value;
            reload_reg <= load_value;
            presc      <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            count <= '0;
            presc <= '0;
          end else if (en) begin
            if (tick) begin
              presc <= '0;
              if (count != '0) begin
                count <= count - 1'b1;
              end else begin
                // Terminal tick: reload_en is only looked at here.
                done <= 1'b1;
                if (reload_en) begin
                  count <= reload_reg;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_down_timer.sv
// tb_down_timer: two timers (PRESCALE 1 and 4) on shared stimulus, checked
// every cycle against an elapsed-cycle model plus directed literal checks.
`default_nettype none

module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid, reload_en, en, abort;
  logic [7:0] load_value;

  logic [7:0] count1, count4;
  logic       busy1, busy4, done1, done4, ready1, ready4;

  int checks = 0;
  int errors = 0;

  down_timer #(.WIDTH(8), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready1),
    .load_value(load_value), .reload_en(reload_en), .en(en), .abort(abort),
    .count(count1), .busy(busy1), .done(done1)
  );

  down_timer #(.WIDTH(8), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready4),
    .load_value(load_value), .reload_en(reload_en), .en(en), .abort(abort),
    .count(count4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count = N - elapsed/P, terminal when elapsed enabled cycles reach (N+1)*P.
  int  mp[2] = '{1, 4};
  bit  mrun[2];
  int  mn[2];
  int  me[2];
  bit  mdone[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mrun[i] = 0; mn[i] = 0; me[i] = 0; mdone[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mdone[i] = 0;
        if (!mrun[i]) begin
          if (load_valid && !abort) begin
            mrun[i] = 1; mn[i] = load_value; me[i] = 0;
          end
        end else if (abort) begin
          mrun[i] = 0;
        end else if (en) begin
          if (me[i] + 1 == (mn[i] + 1) * mp[i]) begin
            mdone[i] = 1;
            if (reload_en) me[i] = 0;
            else mrun[i] = 0;
          end else begin
            me[i]++;
          end
        end
      end
    end
  end

  function automatic int mcount(input int i);
    return mrun[i] ? (mn[i] - me[i] / mp[i]) : 0;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("m1_count", count1, mcount(0));
      chk("m1_busy",  busy1,  int'(mrun[0]));
      chk("m1_done",  done1,  int'(mdone[0]));
      chk("m1_ready", ready1, int'(!mrun[0] && !abort));
      chk("m4_count", count4, mcount(1));
      chk("m4_busy",  busy4,  int'(mrun[1]));
      chk("m4_done",  done4,  int'(mdone[1]));
      chk("m4_ready", ready4, int'(!mrun[1] && !abort));
    end
  end

  task automatic clear();
    @(negedge clk); abort = 1; load_valid = 0; reload_en = 0; en = 1;
    @(negedge clk); abort = 0;
  endtask

  // Presents a load in cycle a; returns at the negedge of cycle a+1.
  task automatic load(input logic [7:0] v);
    load_valid = 1; load_value = v;
    @(negedge clk);
    load_valid = 0;
  endtask

  initial begin
    rst_n = 0; load_valid = 0; reload_en = 0; en = 1; abort = 0; load_value = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_count", count1, 0);
    chk("rst_busy",  busy1,  0);
    chk("rst_done",  done1,  0);
    chk("rst_ready", ready1, 1);

    // One-shot load 3
    @(negedge clk);
    load(3);
    for (int k = 1; k <= 5; k++) begin
      chk("os_count", count1, (k <= 4) ? 4 - k : 0);
      chk("os_done",  done1,  int'(k == 5));
      chk("os_busy",  busy1,  int'(k <= 4));
      if (k == 5) chk("os_ready", ready1, 1);
      @(negedge clk);
    end

    // Auto-reload load 2, then drop reload_en
    clear();
    reload_en = 1;
    load(2);
    for (int k = 1; k <= 13; k++) begin
      if (k <= 10) begin
        chk("ar_count", count1, 2 - ((k - 1) % 3));
        chk("ar_done",  done1,  int'(k >= 4 && (k - 4) % 3 == 0));
        chk("ar_busy",  busy1,  1);
      end else begin
        chk("ar_stop_count", count1, (k == 11) ? 1 : 0);
        chk("ar_stop_done",  done1,  int'(k == 13));
        chk("ar_stop_busy",  busy1,  int'(k != 13));
      end
      if (k == 10) reload_en = 0;
      @(negedge clk);
    end

    // Pause with PRESCALE=4: load 1, 2 enabled, 5 paused, then enabled
    clear();
    load(1);
    for (int k = 1; k <= 15; k++) begin
      if (k <= 13) chk("ps_count", count4, (k <= 9) ? 1 : 0);
      chk("ps_done", done4, int'(k == 14));
      en = !((k + 1) >= 3 && (k + 1) <= 7);
      @(negedge clk);
    end
    en = 1;

    // Abort at count 3
    clear();
    load(5);
    @(negedge clk);
    @(negedge clk);
    chk("ab_pre_count", count1, 3);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("ab_count", count1, 0);
    chk("ab_busy",  busy1,  0);
    chk("ab_done",  done1,  0);
    @(negedge clk);
    chk("ab_done_late", done1, 0);

    // Abort + load_valid in IDLE
    clear();
    abort = 1; load_valid = 1; load_value = 9;
    #1;
    chk("abl_ready", ready1, 0);
    @(negedge clk);
    abort = 0; load_valid = 0;
    chk("abl_busy", busy1, 0);

    // Abort coincident with terminal tick
    clear();
    load(0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abt_done", done1, 0);
    chk("abt_busy", busy1, 0);

    // Load 0
    clear();
    load(0);
    chk("z_count", count1, 0);
    chk("z_busy",  busy1,  1);
    @(negedge clk);
    chk("z_done",  done1,  1);

    // Load 255 with an ignored load mid-run
    clear();
    load(8'hFF);
    for (int k = 1; k <= 258; k++) begin
      chk("ff_count", count1, (k <= 256) ? 256 - k : 0);
      chk("ff_done",  done1,  int'(k == 257));
      load_valid = (k == 100);
      load_value = 8'd7;
      @(negedge clk);
    end
    load_valid = 0;

    // Asynchronous reset mid-run at count 4
    clear();
    load(6);
    @(negedge clk);
    @(negedge clk);
    chk("rr_pre_count", count1, 4);
    #3 rst_n = 0;
    #1;
    chk("rr_count", count1, 0);
    chk("rr_busy",  busy1,  0);
    chk("rr_done",  done1,  0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    load(2);
    for (int k = 1; k <= 4; k++) begin
      chk("rr_os_count", count1, (k <= 3) ? 3 - k : 0);
      chk("rr_os_done",  done1,  int'(k == 4));
      @(negedge clk);
    end

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      load_valid = ($urandom_range(0, 99) < 30);
      abort      = ($urandom_range(0, 99) < 3);
      en         = ($urandom_range(0, 99) < 80);
      reload_en  = 1'($urandom_range(0, 1));
      load_value = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 5));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
